// File: rtl/sweep_game_if.sv
// sweep_game_if: start/button/timeout inputs and game status outputs of the sweep controller.
interface sweep_game_if #(
  parameter int NUM_LEDS = 8,
  parameter int SCORE_W = 7
);
  logic start, button, timeout, enable, game_over;
  logic [1:0] speed, misses;
  logic [NUM_LEDS-1:0] leds;
  logic [SCORE_W-1:0] score;
  modport master(output start, button, timeout, input enable, speed, leds, score, misses, game_over);
  modport slave(input start, button, timeout, output enable, speed, leds, score, misses, game_over);
endinterface

// File: rtl/sweep_game_ctrl.sv
// sweep_game_ctrl: LED sweep reaction game driven by speed-counter timeout pulses.
// Define SWEEP_PASS_MISS_EN to also count an unpressed target pass as a miss.
module sweep_game_ctrl #(
  parameter int NUM_LEDS = 8,
  parameter int TARGET = 3,
  parameter int MAX_MISS = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SCORE_W = 7
) (
  input logic clk,
  input logic rst,
  sweep_game_if.slave bus
);
  localparam int PW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  localparam int HW = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2;
  logic [1:0] state, misses_n;
  logic [PW-1:0] pos, pos_n;
  logic [HW-1:0] hit_cnt;
  logic lock, go, judge, hit, miss, pass_miss, level_up;
  always_comb begin
    go = bus.start && state != RUN;
    judge = state == RUN && bus.button && !lock;
    hit = judge && pos == PW'(TARGET);
    miss = (judge && !hit) || pass_miss;
    misses_n = bus.misses + 2'(miss);
    level_up = hit && hit_cnt == HW'(HITS_PER_LEVEL - 1);
    pos_n = pos == PW'(NUM_LEDS - 1) ? '0 : pos + PW'(1);
  end
`ifdef SWEEP_PASS_MISS_EN
  logic hit_flag;
  always_ff @(posedge clk)
    hit_flag <= (rst || go || bus.timeout) ? 1'b0 : hit_flag | hit;
  assign pass_miss = state == RUN && bus.timeout && pos == PW'(TARGET) && !(hit_flag || hit);
`else
  assign pass_miss = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pos <= '0;
      hit_cnt <= '0;
      lock <= 1'b0;
      bus.enable <= 1'b0;
      bus.speed <= 2'd0;
      bus.leds <= '0;
      bus.score <= '0;
      bus.misses <= 2'd0;
      bus.game_over <= 1'b0;
    end else if (go) begin
      state <= RUN;
      pos <= '0;
      hit_cnt <= '0;
      lock <= 1'b0;
      bus.enable <= 1'b1;
      bus.speed <= 2'd0;
      bus.leds <= NUM_LEDS'(1);
      bus.score <= '0;
      bus.misses <= 2'd0;
      bus.game_over <= 1'b0;
    end else if (state == RUN) begin
      if (hit) begin
        bus.score <= &bus.score ? bus.score : bus.score + SCORE_W'(1);
        hit_cnt <= level_up ? '0 : hit_cnt + HW'(1);
        if (level_up && bus.speed != 2'd2) bus.speed <= bus.speed + 2'd1;
      end
      bus.misses <= misses_n;
      // the game-ending miss wins over a coincident step
      if (misses_n >= 2'(MAX_MISS)) begin
        state <= OVER;
        bus.enable <= 1'b0;
        bus.leds <= '1;
        bus.game_over <= 1'b1;
      end else if (bus.timeout) begin
        pos <= pos_n;
        bus.leds <= NUM_LEDS'(1) << pos_n;
        lock <= 1'b0;
      end else begin
        lock <= lock | judge;
      end
    end
  end
endmodule

// File: tb/tb_sweep_game_ctrl.sv
// tb_sweep_game_ctrl: directed game sequence with a reference model feeding a scoreboard queue.
module tb_sweep_game_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  sweep_game_if #(.NUM_LEDS(8), .SCORE_W(7)) bus();
  sweep_game_ctrl dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic enable;
    logic [1:0] speed;
    logic [7:0] leds;
    logic [6:0] score;
    logic [1:0] misses;
    logic game_over;
  } obs_t;
  obs_t sb[$];
  int checks = 0, failures = 0;
  int st = 0, pos = 0, hc = 0, lock = 0, hflag = 0, score = 0, miss = 0, spd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit r, input bit s, input bit b, input bit t);
    int j, h, pm;
    if (r || (s && st != 1)) begin
      st = r ? 0 : 1;
      pos = 0; hc = 0; lock = 0; hflag = 0; score = 0; miss = 0; spd = 0;
    end else if (st == 1) begin
      j = (b && lock == 0) ? 1 : 0;
      h = (j == 1 && pos == 3) ? 1 : 0;
      pm = 0;
`ifdef SWEEP_PASS_MISS_EN
      pm = (t && pos == 3 && hflag == 0 && h == 0) ? 1 : 0;
`endif
      if (h == 1) begin
        if (score < 127) score++;
        hc++;
        if (hc == 4) begin
          hc = 0;
          if (spd < 2) spd++;
        end
      end
      miss += (j - h) + pm;
      if (miss >= 3) st = 2;
      else if (t) begin
        pos = (pos + 1) % 8;
        lock = 0;
        hflag = 0;
      end else begin
        lock |= j;
        hflag |= h;
      end
    end
  endfunction

  function automatic obs_t predict();
    obs_t e;
    e.enable = st == 1;
    e.speed = spd[1:0];
    e.leds = st == 0 ? 8'h00 : st == 2 ? 8'hFF : 8'(1 << pos);
    e.score = score[6:0];
    e.misses = miss[1:0];
    e.game_over = st == 2;
    return e;
  endfunction

  task automatic compare();
    obs_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL sb_empty got=0 expected=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("enable", bus.enable, e.enable);
      check("speed", bus.speed, e.speed);
      check("leds", bus.leds, e.leds);
      check("score", bus.score, e.score);
      check("misses", bus.misses, e.misses);
      check("game_over", bus.game_over, e.game_over);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit b, input bit t);
    rst = r; bus.start = s; bus.button = b; bus.timeout = t;
    model(r, s, b, t);
    sb.push_back(predict());
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0; bus.button = 1'b0; bus.timeout = 1'b0;
    compare();
  endtask

  task automatic tmo(input int n);
    repeat (n) cyc(0, 0, 0, 1);
  endtask

  task automatic press();
    cyc(0, 0, 1, 0);
  endtask

  task automatic hit_lap();
    tmo(8);
    press();
  endtask

  initial begin
    bus.start = 1'b0; bus.button = 1'b0; bus.timeout = 1'b0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0);
    check("rst_leds", bus.leds, 8'h00);
    check("rst_enable", bus.enable, 1'b0);
    cyc(0, 1, 0, 0);
    check("start_enable", bus.enable, 1'b1);
    check("start_leds", bus.leds, 8'h01);
    tmo(8);
    check("wrap_leds", bus.leds, 8'h01);
    tmo(3);
    press();
    check("hit_leds", bus.leds, 8'h08);
    check("hit_score", bus.score, 7'd1);
    press();
    check("lock_score", bus.score, 7'd1);
    repeat (3) hit_lap();
    check("speed1", bus.speed, 2'd1);
    repeat (8) hit_lap();
    check("speed2", bus.speed, 2'd2);
    repeat (2) hit_lap();
    check("speed_sat", bus.speed, 2'd2);
    check("score14", bus.score, 7'd14);
    tmo(8);
    cyc(0, 0, 1, 1);
    check("same_score", bus.score, 7'd15);
    check("same_leds", bus.leds, 8'h10);
    check("same_misses", bus.misses, 2'd0);
    tmo(4);
    press();
    press();
    check("lock_miss", bus.misses, 2'd1);
    tmo(1);
    press();
    tmo(1);
    press();
    check("over_misses", bus.misses, 2'd3);
    check("over_flag", bus.game_over, 1'b1);
    check("over_enable", bus.enable, 1'b0);
    check("over_leds", bus.leds, 8'hFF);
    check("over_score_hold", bus.score, 7'd15);
    tmo(2);
    check("over_tmo_ignored", bus.leds, 8'hFF);
    cyc(0, 1, 0, 0);
    check("restart_score", bus.score, 7'd0);
    check("restart_misses", bus.misses, 2'd0);
    check("restart_leds", bus.leds, 8'h01);
    press();
    tmo(1);
    press();
    tmo(1);
    cyc(0, 0, 1, 1);
    check("end_step_leds", bus.leds, 8'hFF);
    check("end_step_enable", bus.enable, 1'b0);
    cyc(0, 1, 0, 0);
    tmo(3);
    cyc(0, 1, 0, 0);
    check("start_in_run", bus.leds, 8'h08);
    press();
    repeat (4) hit_lap();
    check("score5", bus.score, 7'd5);
    cyc(1, 0, 0, 0);
    check("midrst_score", bus.score, 7'd0);
    check("midrst_leds", bus.leds, 8'h00);
    tmo(3);
    check("idle_tmo_leds", bus.leds, 8'h00);
    check("idle_tmo_enable", bus.enable, 1'b0);
    cyc(0, 1, 0, 0);
    tmo(3);
    press();
    repeat (129) hit_lap();
    check("score_sat", bus.score, 7'd127);
    check("speed_final", bus.speed, 2'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
